// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 character-LCD controller.
//   - lcd_state_e : controller FSM states (PWRUP exists only with LCD_INIT_EN)
//   - bit positions of the io_lcd command word
//   - command codes that need the long execution wait
//   - power-on initialisation command list
//   - small helpers used for counter sizing and wait selection
// Optional feature macro: LCD_INIT_EN (power-on init sequence).
package lcd_pkg;

`ifdef LCD_INIT_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT, ST_PWRUP
  } lcd_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT
  } lcd_state_e;
`endif

  // io_lcd command word layout
  localparam int ON_BIT   = 31;
  localparam int TGL_BIT  = 30;
  localparam int RS_BIT   = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Function set 8-bit/2-line, display on, clear, entry mode increment
  localparam int         INIT_LEN = 4;
  localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x01) and Home (0x02/0x03; bit 0 is don't-care) need the long wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && ((d == CMD_CLEAR) || (d[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// lcd_ctrl_if: HD44780 parallel pin bus (DB[7:0], RS, RW, EN).
//   master : the controller driving the pins
//   slave  : the LCD module (or a bench monitor) observing them
interface lcd_ctrl_if;
  logic [7:0] lcd_data_o;
  logic       lcd_rs_o;
  logic       lcd_rw_o;
  logic       lcd_en_o;

  modport master (output lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o);
  modport slave  (input  lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o);
endinterface

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: loadable down-counter shared by every timed FSM state.
//   clk_i, rst_ni : clock, async active-low reset (counter -> RST_VAL)
//   load_i        : load load_val_i this cycle (takes priority)
//   load_val_i    : N-1 for an N-cycle state
//   zero_o        : count has reached zero (state may exit on this edge)
// Counts down and saturates at zero.
module lcd_delay_cnt #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 bus controller driven by the memory-mapped io_lcd word.
//   clk_i, rst_ni : clock, async active-low reset
//   lcd_cmd_i     : io_lcd value ([31] power, [30] toggle, [8] RS, [7:0] byte)
//   lcd           : LCD pin bus (DB/RS/RW/EN), master side
//   lcd_on_o      : registered copy of lcd_cmd_i[31]
//   busy_o        : request accepted and not yet finished its execution wait
//   dbg_state_o   : current FSM state
// Optional feature macro: LCD_INIT_EN adds a power-up delay followed by a
// fixed init command sequence before user requests are served.
//
// Request handshake: a request is "valid" while lcd_cmd_i[30] differs from
// the last accepted toggle; the controller is "ready" only in IDLE. Acceptance
// happens on the edge where both hold, captures RS/DATA from that same cycle
// and raises busy_o. A toggle that flips while busy stays pending until the
// next IDLE cycle; flipping it twice while busy cancels the request.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int EN_CYC      = 25,
  parameter int HOLD_CYC    = 2,
  parameter int EXEC_CYC    = 2000,
  parameter int CLEAR_CYC   = 82000,
  parameter int POWERUP_CYC = 750000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       lcd_cmd_i,
  lcd_ctrl_if.master        lcd,
  output logic              lcd_on_o,
  output logic              busy_o,
  output lcd_state_e        dbg_state_o
);

  localparam int XFER_MAX = max_int(max_int(max_int(SETUP_CYC, EN_CYC),
                                            max_int(HOLD_CYC, EXEC_CYC)), CLEAR_CYC);
`ifdef LCD_INIT_EN
  localparam int CNT_MAX = max_int(XFER_MAX, POWERUP_CYC);
`else
  localparam int CNT_MAX = XFER_MAX;
`endif
  localparam int CW = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYC - 1);

`ifdef LCD_INIT_EN
  // The power-up wait starts straight out of reset, so the counter resets
  // to its load value instead of needing a separate load cycle.
  localparam logic [CW-1:0] CNT_RST   = CW'(POWERUP_CYC - 1);
  localparam lcd_state_e    RST_STATE = ST_PWRUP;
  localparam logic          RST_BUSY  = 1'b1;
`else
  localparam logic [CW-1:0] CNT_RST   = '0;
  localparam lcd_state_e    RST_STATE = ST_IDLE;
  localparam logic          RST_BUSY  = 1'b0;
`endif

  lcd_state_e    state_q, state_d;
  logic          cnt_load, cnt_zero;
  logic [CW-1:0] cnt_val;
  logic          accept, latch, new_rs;
  logic [7:0]    new_data;
  logic          tgl_seen_q, rs_q, long_q, en_q, busy_q, on_q;
  logic [7:0]    data_q;

`ifdef LCD_INIT_EN
  logic       init_q, init_done;
  logic [1:0] idx_q, idx_d;
`endif

  lcd_delay_cnt #(.W(CW), .RST_VAL(CNT_RST)) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    accept   = 1'b0;
    latch    = 1'b0;
    new_rs   = 1'b0;
    new_data = 8'h00;
`ifdef LCD_INIT_EN
    idx_d     = idx_q;
    init_done = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (lcd_cmd_i[TGL_BIT] != tgl_seen_q) begin
          state_d  = ST_SETUP;
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
          accept   = 1'b1;
          latch    = 1'b1;
          new_rs   = lcd_cmd_i[RS_BIT];
          new_data = lcd_cmd_i[DATA_MSB:DATA_LSB];
        end
      end
      ST_SETUP: if (cnt_zero) begin
        state_d  = ST_PULSE;
        cnt_load = 1'b1;
        cnt_val  = EN_LD;
      end
      ST_PULSE: if (cnt_zero) begin
        state_d  = ST_HOLD;
        cnt_load = 1'b1;
        cnt_val  = HOLD_LD;
      end
      ST_HOLD: if (cnt_zero) begin
        state_d  = ST_WAIT;
        cnt_load = 1'b1;
        cnt_val  = long_q ? CLEAR_LD : EXEC_LD;
      end
      ST_WAIT: if (cnt_zero) begin
`ifdef LCD_INIT_EN
        if (init_q && (idx_q != 2'(INIT_LEN - 1))) begin
          state_d  = ST_SETUP;
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
          idx_d    = idx_q + 2'd1;
          latch    = 1'b1;
          new_data = INIT_CMDS[idx_d];
        end else begin
          state_d   = ST_IDLE;
          init_done = init_q;
        end
`else
        state_d = ST_IDLE;
`endif
      end
`ifdef LCD_INIT_EN
      ST_PWRUP: if (cnt_zero) begin
        state_d  = ST_SETUP;
        cnt_load = 1'b1;
        cnt_val  = SETUP_LD;
        latch    = 1'b1;
        new_data = INIT_CMDS[0];
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // EN and busy are registered from the next state so the pins are
  // glitch-free and change exactly on the state-transition edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RST_STATE;
      tgl_seen_q <= 1'b0;
      rs_q       <= 1'b0;
      data_q     <= 8'h00;
      long_q     <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= RST_BUSY;
      on_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= (state_d == ST_PULSE);
      busy_q  <= (state_d != ST_IDLE);
      on_q    <= lcd_cmd_i[ON_BIT];
      if (accept) tgl_seen_q <= lcd_cmd_i[TGL_BIT];
      if (latch) begin
        rs_q   <= new_rs;
        data_q <= new_data;
        long_q <= is_long_cmd(new_rs, new_data);
      end
    end
  end

`ifdef LCD_INIT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q <= 1'b1;
      idx_q  <= 2'd0;
    end else begin
      idx_q <= idx_d;
      if (init_done) init_q <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^lcd_cmd_i[29:9];
`else
  logic unused_ok;
  assign unused_ok = ^{lcd_cmd_i[29:9], POWERUP_CYC[0]};
`endif

  assign lcd.lcd_data_o = data_q;
  assign lcd.lcd_rs_o   = rs_q;
  assign lcd.lcd_rw_o   = 1'b0;
  assign lcd.lcd_en_o   = en_q;
  assign lcd_on_o       = on_q;
  assign busy_o         = busy_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed bench for lcd_ctrl with small timing parameters.
module tb_lcd_ctrl;
  import lcd_pkg::*;

  localparam int SETUP = 2;
  localparam int ENW   = 4;
  localparam int HOLD  = 2;
  localparam int EXEC  = 10;
  localparam int CLEAR = 30;
  localparam int PWRUP = 20;

`ifdef LCD_INIT_EN
  localparam logic       EXP_RST_BUSY  = 1'b1;
  localparam lcd_state_e EXP_RST_STATE = ST_PWRUP;
`else
  localparam logic       EXP_RST_BUSY  = 1'b0;
  localparam lcd_state_e EXP_RST_STATE = ST_IDLE;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] lcd_cmd = 32'h0;
  logic        lcd_on, busy;
  lcd_state_e  dbg_state;

  lcd_ctrl_if lcd();

  lcd_ctrl #(
    .SETUP_CYC(SETUP), .EN_CYC(ENW), .HOLD_CYC(HOLD),
    .EXEC_CYC(EXEC), .CLEAR_CYC(CLEAR), .POWERUP_CYC(PWRUP)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .lcd_cmd_i   (lcd_cmd),
    .lcd         (lcd),
    .lcd_on_o    (lcd_on),
    .busy_o      (busy),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         failures = 0;
  int         pushes = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
    pushes++;
  endtask

  // Bus monitor: samples 1 time unit after each rising edge and records
  // EN/busy edges in cycle numbers; EN rising edges are scored against exp_q.
  int         cyc = 0, pulses = 0, en_cnt = 0, en_width = 0, en_rise_cyc = 0;
  int         busy_rise_cyc = 0, busy_fall_cyc = 0, busy_len = 0, idle_gap = 0;
  int         stable_err = 0;
  logic       en_prev = 1'b0, busy_prev = 1'b0, en_rs = 1'b0;
  logic [7:0] en_data = 8'h00;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (busy && !busy_prev) begin
      busy_rise_cyc = cyc;
      idle_gap      = cyc - busy_fall_cyc;
    end
    if (!busy && busy_prev) begin
      busy_fall_cyc = cyc;
      busy_len      = cyc - busy_rise_cyc;
    end
    if (lcd.lcd_en_o && !en_prev) begin
      en_rise_cyc = cyc;
      en_cnt      = 0;
      en_data     = lcd.lcd_data_o;
      en_rs       = lcd.lcd_rs_o;
      pulses++;
      chk("sb_pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("sb_en_data", {24'd0, en_data}, {24'd0, exp_q.pop_front()});
    end
    if (lcd.lcd_en_o) en_cnt++;
    if ((lcd.lcd_en_o || dbg_state == ST_HOLD) &&
        (lcd.lcd_data_o !== en_data || lcd.lcd_rs_o !== en_rs)) stable_err++;
    if (!lcd.lcd_en_o && en_prev) en_width = en_cnt;
    en_prev   = lcd.lcd_en_o;
    busy_prev = busy;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy === 1'b1 && n < limit) begin
      step();
      n++;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic xfer(input string tag, input logic [31:0] cmd, input int exp_len);
    expect_byte(cmd[7:0]);
    @(negedge clk); lcd_cmd = cmd;
    step();
    chk({tag, "_busy_at_accept"}, {31'd0, busy}, 32'd1);
    chk({tag, "_data_at_accept"}, {24'd0, lcd.lcd_data_o}, {24'd0, cmd[7:0]});
    chk({tag, "_rs_at_accept"}, {31'd0, lcd.lcd_rs_o}, {31'd0, cmd[8]});
    wait_idle(300);
    @(negedge clk);
    chk({tag, "_setup_cycles"}, en_rise_cyc - busy_rise_cyc, SETUP);
    chk({tag, "_en_width"}, en_width, ENW);
    chk({tag, "_busy_len"}, busy_len, exp_len);
  endtask

  task automatic run_init();
`ifdef LCD_INIT_EN
    expect_byte(8'h38); expect_byte(8'h0C); expect_byte(8'h01); expect_byte(8'h06);
    step();
    wait_idle(2000);
    @(negedge clk);
    chk("init_pulses", pulses, pushes);
    chk("init_busy_after_last_exec", busy_fall_cyc - (en_rise_cyc + ENW), HOLD + EXEC);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    lcd_cmd = 32'h0;
    repeat (3) step();
    chk("rst_data", {24'd0, lcd.lcd_data_o}, 32'd0);
    chk("rst_rs", {31'd0, lcd.lcd_rs_o}, 32'd0);
    chk("rst_rw", {31'd0, lcd.lcd_rw_o}, 32'd0);
    chk("rst_en", {31'd0, lcd.lcd_en_o}, 32'd0);
    chk("rst_on", {31'd0, lcd_on}, 32'd0);
    chk("rst_busy", {31'd0, busy}, {31'd0, EXP_RST_BUSY});
    chk("rst_state", 32'(dbg_state), 32'(EXP_RST_STATE));
    @(negedge clk); rst_n = 1'b1;
    run_init();

    // data write: 2+4+2+10 busy cycles
    xfer("data", 32'h4000_0141, 18);
    // clear command: toggle back to 0, 2+4+2+30
    xfer("clear", 32'h0000_0001, 38);

    // toggle again during PULSE: second request waits for the first to end
    expect_byte(8'h41);
    expect_byte(8'h42);
    @(negedge clk); lcd_cmd = 32'h4000_0041;
    step();
    repeat (2) step();
    chk("b2b_in_pulse", {31'd0, lcd.lcd_en_o}, 32'd1);
    @(negedge clk); lcd_cmd = 32'h0000_0142;
    wait_idle(300);
    step();
    chk("b2b_second_busy", {31'd0, busy}, 32'd1);
    chk("b2b_second_data", {24'd0, lcd.lcd_data_o}, 32'h42);
    chk("b2b_second_rs", {31'd0, lcd.lcd_rs_o}, 32'd1);
    @(negedge clk);
    chk("b2b_first_len", busy_len, 18);
    chk("b2b_idle_gap", idle_gap, 1);
    wait_idle(300);
    @(negedge clk);
    chk("b2b_second_len", busy_len, 18);
    chk("b2b_second_setup", en_rise_cyc - busy_rise_cyc, SETUP);

    // two toggles during one transfer cancel out
    expect_byte(8'h43);
    @(negedge clk); lcd_cmd = 32'h4000_0043;
    step();
    repeat (2) step();
    @(negedge clk); lcd_cmd = 32'h0000_0044;
    @(negedge clk); lcd_cmd = 32'h4000_0045;
    wait_idle(300);
    repeat (10) step();
    chk("dbl_no_second_busy", {31'd0, busy}, 32'd0);
    chk("dbl_pulse_count", pulses, pushes);

    // asynchronous reset in the middle of the EN pulse
    expect_byte(8'h46);
    @(negedge clk); lcd_cmd = 32'h0000_0046;
    step();
    repeat (3) step();
    chk("rstmid_in_pulse", {31'd0, lcd.lcd_en_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    lcd_cmd = 32'h0;
    #1;
    chk("rstmid_en", {31'd0, lcd.lcd_en_o}, 32'd0);
    chk("rstmid_data", {24'd0, lcd.lcd_data_o}, 32'd0);
    chk("rstmid_rs", {31'd0, lcd.lcd_rs_o}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, {31'd0, EXP_RST_BUSY});
    @(negedge clk); rst_n = 1'b1;
    run_init();
    repeat (10) step();
    chk("rstmid_no_transfer_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_pulse_count", pulses, pushes);

    // display power bit: registered, no transfer
    @(negedge clk); lcd_cmd = 32'h8000_0000;
    #1;
    chk("on_before_edge", {31'd0, lcd_on}, 32'd0);
    step();
    chk("on_after_edge", {31'd0, lcd_on}, 32'd1);
    chk("on_no_busy", {31'd0, busy}, 32'd0);
    repeat (5) step();
    chk("on_pulse_count", pulses, pushes);
    @(negedge clk); lcd_cmd = 32'h0;
    step();
    chk("on_cleared", {31'd0, lcd_on}, 32'd0);

    // end-of-run scoreboard state
    chk("stable_during_en_hold", stable_err, 0);
    chk("sb_queue_drained", exp_q.size(), 0);
    chk("rw_low", {31'd0, lcd.lcd_rw_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
